result_drain: RTL
=================

Name: result_drain

Overview:
- Read-side counterpart of the matmul controller's result write-back. After compute finishes, it reads the 64-bit results from the two output BRAMs (B and C) and streams them out.
- Output is a valid/ready stream for DMA to PS memory.
- Per group g, B[g] is emitted first, then C[g], for all groups.
- Reads are credit-limited prefetches into a small FIFO, so stream backpressure never drops or duplicates a word.

Parameters:
- DATA_WIDTH_O, 64, width of BRAM read data and stream data.
- ADDR_WIDTH, 32, BRAM byte-address width.
- NUM_GROUP, 257, number of result groups per BRAM.
- READ_LATENCY, 1, cycles from bram_en_x to valid bram_dout_x. Legal values are 1 or 2.
- BUF_DEPTH, 4, prefetch FIFO depth. Must be a power of 2 and at least READ_LATENCY+1.

Ports:
- clk  in  1  clock. Also drives both BRAM clocks.
- rst  in  1  synchronous reset, active-high.
- start  in  1  one-cycle pulse that begins a drain. Honoured only in IDLE.
- busy  out  1  high whenever state is not IDLE.
- done  out  1  one-cycle pulse after the last beat is accepted.
- bram_clk_b / bram_clk_c  out  1  equal to clk.
- bram_rst_b / bram_rst_c  out  1  equal to rst.
- bram_en_b / bram_en_c  out  1  read enable, registered.
- bram_we_b / bram_we_c  out  8  always 8'h00.
- bram_addr_b / bram_addr_c  out  ADDR_WIDTH  byte address, registered.
- bram_dout_b / bram_dout_c  in  DATA_WIDTH_O  read data.
- m_tdata  out  DATA_WIDTH_O  stream data. Driven from the FIFO head.
- m_tvalid  out  1  stream valid.
- m_tready  in  1  stream ready.
- m_tlast  out  1  high on the final beat only, C[NUM_GROUP-1].

Behaviour:
- Reset values, all synchronous on rst: state=IDLE; busy=0, done=0; bram_en_b/c=0; bram_addr_b/c=0; m_tvalid=0, m_tlast=0; FIFO empty; all counters and the in-flight pipe cleared.
- Reset mid-operation takes effect on the next edge. In-flight reads are discarded and no further beat is emitted.
- Read index rd_idx counts 0..2*NUM_GROUP-1.
  - bit0=0 selects port B, bit0=1 selects port C.
  - group = rd_idx>>1; address = group<<3 (byte address, 8 bytes per word).
- Issue rule: one read per cycle at most. A read is issued when all of the following hold:
  - state is RUN;
  - rd_idx < 2*NUM_GROUP;
  - fifo_count + inflight < BUF_DEPTH.
- On an issue cycle, the next edge registers bram_en_x=1 and bram_addr_x. The other port's en is 0.
- Each issue pushes a {valid, port, last} tag into a READ_LATENCY-deep pipe. The tag exits on the cycle bram_dout_x is valid, and the selected dout plus the last flag are written into the FIFO.
- Credits guarantee no FIFO overflow. Overflow is an assertion failure.
- Stream side:
  - m_tvalid = FIFO not empty.
  - A pop occurs when m_tvalid && m_tready.
  - Data and last are held stable while m_tvalid && !m_tready.
- A FIFO push and pop in the same cycle leave the count unchanged.
- FSM:
  - IDLE: start -> RUN, with rd_idx=0, beat counter=0, FIFO cleared. start is ignored in any other state.
  - RUN: when the read with rd_idx=2*NUM_GROUP-1 issues -> DRAIN.
  - DRAIN: on the handshake of the m_tlast beat -> DONE.
  - DONE: done=1 for one cycle -> IDLE.
- Throughput: with m_tready held high, one beat per cycle after the first beat.
- First-beat latency from the start pulse is READ_LATENCY+2 cycles: 1 cycle to enter RUN, 1 cycle for the registered en, then READ_LATENCY.
- Total beats = 2*NUM_GROUP = 514 at the default.
- If m_tready is low for any length of time, reads stop once BUF_DEPTH words are buffered or in flight, and resume when credit returns.
- Address arithmetic is done at ADDR_WIDTH. The maximum address is (NUM_GROUP-1)<<3 = 0x800 at the default.

Optional Feature:
- Macro DRAIN_STALL_CNT_EN.
- When defined:
  - adds output stall_cycles [31:0];
  - the counter increments every cycle with busy && m_tvalid && !m_tready, and saturates at 32'hFFFF_FFFF;
  - it is cleared on an accepted start and on rst, and holds its value in IDLE.
- When not defined: the port and its logic are absent, and behaviour is otherwise identical.

Test Plan:
- NUM_GROUP=257, READ_LATENCY=1, m_tready=1, B[g]=g, C[g]=g|0x1_0000_0000 -> the stream carries 0, 0x100000000, 1, 0x100000001, ..., then 256 and 0x100000100. 514 beats, tlast only on beat 514, first beat at start+3, done exactly 1 cycle after the last handshake, busy low afterwards.
- Random m_tready at 30% duty -> identical data order, no gaps or duplicates, m_tdata/m_tlast stable while stalled, FIFO never exceeds BUF_DEPTH=4. With DRAIN_STALL_CNT_EN, stall_cycles equals the count of valid&&!ready cycles.
- m_tready=0 for 20 cycles after start -> exactly 4 reads issued (addresses B 0x0, C 0x0, B 0x8, C 0x8), en stays low afterwards, and the full order is correct after ready=1.
- READ_LATENCY=2, NUM_GROUP=3 -> 6 beats in order B0, C0, B1, C1, B2, C2. bram_we_b/c stay 0 throughout.
- rst pulsed while at beat 100 -> all outputs return to reset values on the next edge. A following start drains all 514 beats again from B[0].
- start pulsed during RUN and during DONE -> ignored: no counter restart, and only one done pulse is produced.

Source files
------------

// File: rtl/result_drain_if.sv
// result_drain_if: control, dual-BRAM read and output stream bundle for result_drain.
// The master side is the drain engine; the slave side is the surrounding system
// (controller, the two result BRAMs and the DMA stream sink).
interface result_drain_if #(
    parameter int DATA_WIDTH_O = 64,
    parameter int ADDR_WIDTH   = 32
);
    logic                    start;
    logic                    busy;
    logic                    done;
    logic                    bram_clk_b;
    logic                    bram_clk_c;
    logic                    bram_rst_b;
    logic                    bram_rst_c;
    logic                    bram_en_b;
    logic                    bram_en_c;
    logic [7:0]              bram_we_b;
    logic [7:0]              bram_we_c;
    logic [ADDR_WIDTH-1:0]   bram_addr_b;
    logic [ADDR_WIDTH-1:0]   bram_addr_c;
    logic [DATA_WIDTH_O-1:0] bram_dout_b;
    logic [DATA_WIDTH_O-1:0] bram_dout_c;
    logic [DATA_WIDTH_O-1:0] m_tdata;
    logic                    m_tvalid;
    logic                    m_tready;
    logic                    m_tlast;

    modport master (
        input  start, bram_dout_b, bram_dout_c, m_tready,
        output busy, done,
        output bram_clk_b, bram_clk_c, bram_rst_b, bram_rst_c,
        output bram_en_b, bram_en_c, bram_we_b, bram_we_c, bram_addr_b, bram_addr_c,
        output m_tdata, m_tvalid, m_tlast
    );

    modport slave (
        output start, bram_dout_b, bram_dout_c, m_tready,
        input  busy, done,
        input  bram_clk_b, bram_clk_c, bram_rst_b, bram_rst_c,
        input  bram_en_b, bram_en_c, bram_we_b, bram_we_c, bram_addr_b, bram_addr_c,
        input  m_tdata, m_tvalid, m_tlast
    );
endinterface

// File: rtl/result_drain.sv
// result_drain: reads the B and C result BRAMs in the order B[0], C[0], B[1], C[1], ...
// and streams the words out over valid/ready. Reads are credit-limited prefetches into
// a small fall-through FIFO so backpressure never drops or duplicates a word.
// Optional feature macro: DRAIN_STALL_CNT_EN adds the stall_cycles output.
module result_drain #(
    parameter int DATA_WIDTH_O = 64,
    parameter int ADDR_WIDTH   = 32,
    parameter int NUM_GROUP    = 257,
    parameter int READ_LATENCY = 1,
    parameter int BUF_DEPTH    = 4
) (
    input  logic clk,
    input  logic rst,
    result_drain_if.master bus
`ifdef DRAIN_STALL_CNT_EN
    ,
    output logic [31:0] stall_cycles
`endif
);
    localparam int TOTAL    = 2 * NUM_GROUP;
    localparam int LAST_IDX = TOTAL - 1;
    localparam int IDX_W    = $clog2(TOTAL + 1);
    // One stage covers the registered bram_en, the rest match the BRAM read latency.
    localparam int PIPE     = READ_LATENCY + 1;
    localparam int PTR_W    = $clog2(BUF_DEPTH);
    localparam int CNT_W    = $clog2(BUF_DEPTH + 1);
    localparam int INF_W    = $clog2(PIPE + 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t                  state_q;
    logic                    busy_q;
    logic                    done_q;
    logic [IDX_W-1:0]        rd_idx_q;
    logic                    en_b_q;
    logic                    en_c_q;
    logic [ADDR_WIDTH-1:0]   addr_b_q;
    logic [ADDR_WIDTH-1:0]   addr_c_q;
    logic [ADDR_WIDTH-1:0]   addr_d;
    logic [PIPE-1:0]         pipe_vld_q;
    logic [PIPE-1:0]         pipe_port_q;
    logic [PIPE-1:0]         pipe_last_q;
    logic [INF_W-1:0]        inflight;
    logic [DATA_WIDTH_O:0]   fifo_mem_q [BUF_DEPTH];
    logic [PTR_W-1:0]        wr_ptr_q;
    logic [PTR_W-1:0]        rd_ptr_q;
    logic [CNT_W-1:0]        fifo_count_q;
    logic                    fifo_empty;
    logic                    issue;
    logic                    is_last_idx;
    logic                    push;
    logic                    pop;
    logic                    start_ok;
    logic [DATA_WIDTH_O:0]   push_word;
    logic [DATA_WIDTH_O:0]   head_word;

    assign start_ok    = (state_q == IDLE) && bus.start;
    assign is_last_idx = (rd_idx_q == IDX_W'(LAST_IDX));
    // Byte address of the group: 8 bytes per 64-bit word.
    assign addr_d      = ADDR_WIDTH'(rd_idx_q >> 1) << 3;

    // Count reads issued but not yet landed in the FIFO (the credit pool).
    always_comb begin
        inflight = '0;
        for (int i = 0; i < PIPE; i++) begin
            inflight = inflight + INF_W'(pipe_vld_q[i]);
        end
    end

    // Issue at most one read per cycle while credits remain.
    always_comb begin
        issue = (state_q == RUN)
             && (32'(rd_idx_q) < 32'(TOTAL))
             && ((32'(fifo_count_q) + 32'(inflight)) < 32'(BUF_DEPTH));
    end

    // Word returning from the BRAM this cycle, tagged with its last flag.
    assign push      = pipe_vld_q[PIPE-1];
    assign push_word = {pipe_last_q[PIPE-1],
                        pipe_port_q[PIPE-1] ? bus.bram_dout_c : bus.bram_dout_b};

    // Fall-through head: an empty FIFO presents the arriving word directly, so the
    // first beat is visible in the same cycle the BRAM data becomes valid. A stalled
    // word is written into the FIFO at the head slot, so it stays stable.
    assign fifo_empty   = (fifo_count_q == '0);
    assign head_word    = fifo_empty ? push_word : fifo_mem_q[rd_ptr_q];
    assign bus.m_tvalid = !fifo_empty || push;
    assign bus.m_tdata  = head_word[DATA_WIDTH_O-1:0];
    assign bus.m_tlast  = head_word[DATA_WIDTH_O] && bus.m_tvalid;
    assign pop          = bus.m_tvalid && bus.m_tready;

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.bram_clk_b  = clk;
    assign bus.bram_clk_c  = clk;
    assign bus.bram_rst_b  = rst;
    assign bus.bram_rst_c  = rst;
    assign bus.bram_we_b   = 8'h00;
    assign bus.bram_we_c   = 8'h00;
    assign bus.bram_en_b   = en_b_q;
    assign bus.bram_en_c   = en_c_q;
    assign bus.bram_addr_b = addr_b_q;
    assign bus.bram_addr_c = addr_c_q;

    // Control FSM: sequences a drain and produces the registered busy/done outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            rd_idx_q <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        state_q  <= RUN;
                        busy_q   <= 1'b1;
                        rd_idx_q <= '0;
                    end
                end
                RUN: begin
                    if (issue) begin
                        rd_idx_q <= rd_idx_q + 1'b1;
                        if (is_last_idx) begin
                            state_q <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (pop && bus.m_tlast) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // Registered BRAM read enables and addresses; only the selected port is enabled.
    always_ff @(posedge clk) begin
        if (rst) begin
            en_b_q   <= 1'b0;
            en_c_q   <= 1'b0;
            addr_b_q <= '0;
            addr_c_q <= '0;
        end else begin
            en_b_q <= issue && !rd_idx_q[0];
            en_c_q <= issue && rd_idx_q[0];
            if (issue && !rd_idx_q[0]) begin
                addr_b_q <= addr_d;
            end
            if (issue && rd_idx_q[0]) begin
                addr_c_q <= addr_d;
            end
        end
    end

    // Tag pipe: follows each read until its data is valid on the BRAM output.
    always_ff @(posedge clk) begin
        if (rst) begin
            pipe_vld_q  <= '0;
            pipe_port_q <= '0;
            pipe_last_q <= '0;
        end else begin
            pipe_vld_q  <= {pipe_vld_q[PIPE-2:0], issue};
            pipe_port_q <= {pipe_port_q[PIPE-2:0], rd_idx_q[0]};
            pipe_last_q <= {pipe_last_q[PIPE-2:0], is_last_idx};
        end
    end

    // FIFO storage, no reset needed: occupancy is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem_q[wr_ptr_q] <= push_word;
        end
    end

    // FIFO pointers and occupancy; a simultaneous push and pop keeps the count.
    always_ff @(posedge clk) begin
        if (rst || start_ok) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            fifo_count_q <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   fifo_count_q <= fifo_count_q + 1'b1;
                2'b01:   fifo_count_q <= fifo_count_q - 1'b1;
                default: fifo_count_q <= fifo_count_q;
            endcase
        end
    end

    // Credits must make overflow impossible.
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(push && !pop && (fifo_count_q == CNT_W'(BUF_DEPTH))));
        end
    end

`ifdef DRAIN_STALL_CNT_EN
    logic [31:0] stall_cycles_q;

    // Saturating count of cycles the sink held off a valid beat during a drain.
    always_ff @(posedge clk) begin
        if (rst || start_ok) begin
            stall_cycles_q <= '0;
        end else if (busy_q && bus.m_tvalid && !bus.m_tready && (stall_cycles_q != 32'hFFFF_FFFF)) begin
            stall_cycles_q <= stall_cycles_q + 32'd1;
        end
    end

    assign stall_cycles = stall_cycles_q;
`endif

endmodule
